// File: rtl/ubus_rr_arbiter.sv
// ubus_rr_arbiter: central UBUS controller, round-robin grant plus START/ADDR/DATA phase tracking.
// Define UBUS_ARB_TIMEOUT_EN to add the DATA-phase watchdog (TIMEOUT_CYCLES, arb_timeout).
module ubus_rr_arbiter #(
    parameter int NUM_MASTERS = 4
`ifdef UBUS_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                   ubus_clock,
    input  logic                   ubus_reset,
    input  logic [NUM_MASTERS-1:0] ubus_req,
    output logic [NUM_MASTERS-1:0] ubus_gnt,
    output logic                   ubus_start,
    input  logic                   ubus_bip,
    input  logic                   ubus_wait,
    input  logic                   ubus_error,
    output wire                    ubus_read,
    output wire                    ubus_write
`ifdef UBUS_ARB_TIMEOUT_EN
    ,
    output logic                   arb_timeout
`endif
);

    localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [2:0] {
        ST_RST,
        ST_START,
        ST_NOOP,
        ST_ADDR,
        ST_DATA
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [PTR_W-1:0]         rr_ptr;
    logic [PTR_W-1:0]         pick_idx;
    logic                     pick_vld;
    logic [NUM_MASTERS-1:0]   gnt_d;
    logic                     noop_q;
    int                       slot;
`ifdef UBUS_ARB_TIMEOUT_EN
    logic [7:0]               wdog;
    logic                     timeout_d;
`endif

    // Walk downward so the requester closest after rr_ptr is the last (winning) assignment.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        slot     = 0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            slot = int'(rr_ptr) + i;
            if (slot >= NUM_MASTERS) slot = slot - NUM_MASTERS;
            if (ubus_req[PTR_W'(slot)]) begin
                pick_vld = 1'b1;
                pick_idx = PTR_W'(slot);
            end
        end
        gnt_d = '0;
        if (pick_vld) gnt_d[pick_idx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
`ifdef UBUS_ARB_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_RST:   state_d = ST_START;
            ST_START: state_d = (ubus_gnt != '0) ? ST_ADDR : ST_NOOP;
            ST_NOOP:  state_d = ST_START;
            ST_ADDR:  state_d = ST_DATA;
            ST_DATA: begin
                if (ubus_error || (!ubus_bip && !ubus_wait)) begin
                    state_d = ST_START;
                end
`ifdef UBUS_ARB_TIMEOUT_EN
                else if (wdog >= 8'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = ST_START;
                    timeout_d = 1'b1;
                end
`endif
            end
            default:  state_d = ST_RST;
        endcase
    end

    // Outputs are registered from the next state so they hold for the whole state cycle.
    always_ff @(posedge ubus_clock or posedge ubus_reset) begin
        if (ubus_reset) begin
            state_q    <= ST_RST;
            ubus_start <= 1'b0;
            ubus_gnt   <= '0;
            noop_q     <= 1'b0;
            rr_ptr     <= PTR_W'(NUM_MASTERS - 1);
        end else begin
            state_q    <= state_d;
            ubus_start <= (state_d == ST_START);
            noop_q     <= (state_d == ST_NOOP);
            if (state_d == ST_START) begin
                ubus_gnt <= gnt_d;
                if (pick_vld) rr_ptr <= pick_idx;
            end else begin
                ubus_gnt <= '0;
            end
        end
    end

`ifdef UBUS_ARB_TIMEOUT_EN
    // wdog holds the number of DATA cycles already completed in the current transfer.
    always_ff @(posedge ubus_clock or posedge ubus_reset) begin
        if (ubus_reset) begin
            wdog        <= 8'd0;
            arb_timeout <= 1'b0;
        end else begin
            arb_timeout <= timeout_d;
            if (state_q == ST_DATA && state_d == ST_DATA) wdog <= wdog + 8'd1;
            else                                         wdog <= 8'd0;
        end
    end
`endif

    assign ubus_read  = noop_q ? 1'b0 : 1'bz;
    assign ubus_write = noop_q ? 1'b0 : 1'bz;

endmodule
